// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128/256 encryptor, one round per clock
// Round keys are expanded on the fly from a sliding key register alongside the data rounds.
module aes_encrypt_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [127:0]        Block,
  input  logic [KEY_BITS-1:0] Key,
  output logic                ready,
  output logic                result_valid,
  output logic [127:0]        Result
);
  localparam int NR = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] NR_C = 4'(NR);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_encrypt_iter: KEY_BITS must be 128 or 256");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte n of the state sits at bits 127-8n; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [127:0]          s_q, s_d;
  logic [127:0]          res_q, res_d;
  logic [KEY_BITS-1:0]   k_q, k_d, k_next;
  logic                  vld_q, vld_d;
  logic [127:0]          rk, sr, round_out;

  generate
    if (KEY_BITS == 256) begin : g_ks256
      // k_q holds words w[4(r-1)] .. w[4r+3]; the low half is round key r.
      logic [31:0] t, n0, n1, n2, n3;
      always_comb begin
        t = cnt_q[0] ? (sub_word(rot_word(k_q[31:0])) ^ {rcon(4'((cnt_q + 4'd1) >> 1)), 24'h0})
                     : sub_word(k_q[31:0]);
        n0 = k_q[255:224] ^ t;
        n1 = k_q[223:192] ^ n0;
        n2 = k_q[191:160] ^ n1;
        n3 = k_q[159:128] ^ n2;
        rk = k_q[127:0];
        k_next = {k_q[127:0], n0, n1, n2, n3};
      end
    end else begin : g_ks128
      // k_q holds round key r-1; round key r is derived combinationally.
      logic [31:0] t, n0, n1, n2, n3;
      always_comb begin
        t  = sub_word(rot_word(k_q[31:0])) ^ {rcon(cnt_q), 24'h0};
        n0 = k_q[127:96] ^ t;
        n1 = k_q[95:64] ^ n0;
        n2 = k_q[63:32] ^ n1;
        n3 = k_q[31:0] ^ n2;
        rk = {n0, n1, n2, n3};
        k_next = rk;
      end
    end
  endgenerate

  assign sr        = sub_shift(s_q);
  assign round_out = ((cnt_q == NR_C) ? sr : mix_columns(sr)) ^ rk;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    k_d     = k_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = Block ^ Key[KEY_BITS-1 -: 128];
          k_d     = Key;
          cnt_d   = 4'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_d = round_out;
        k_d = k_next;
        if (cnt_q == NR_C) begin
          res_d   = round_out;
          vld_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      s_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      k_q     <= k_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign result_valid = vld_q;
  assign Result       = res_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - scoreboard bench for AES-128 and AES-256 instances
module tb_aes_encrypt_iter;
  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic [127:0] blk0, blk1, key0;
  logic [255:0] key1;
  logic rdy0, rdy1, rv0, rv1;
  logic [127:0] res0, res1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] res;
    int acc;
    int due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [127:0] last_res [2];
  logic [7:0] sb [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_encrypt_iter #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst_n(rst_n), .start(start0), .Block(blk0), .Key(key0),
    .ready(rdy0), .result_valid(rv0), .Result(res0));

  aes_encrypt_iter #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst_n(rst_n), .start(start1), .Block(blk1), .Key(key1),
    .ready(rdy1), .result_valid(rv1), .Result(res1));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: textbook FIPS-197 with a full key schedule array.
  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11b;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [31:0] tmp;
    logic [127:0] out;
    int rc = 1;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {8'(rc), 24'h0};
        rc = gmul(rc, 2);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < nr)
            s[r][c] = 8'(gmul(2, int'(t[r][c])) ^ gmul(3, int'(t[(r+1)%4][c])))
                      ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) out[127-8*(r+4*c) -: 8] = s[r][c];
    return out;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(input int sel, input logic rv, input logic [127:0] res, input logic rdy);
    exp_t e;
    logic exp_rdy;
    if (rv) begin
      if (qsize(sel) == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid%0d actual=1 required=0", sel);
      end else begin
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("result%0d", sel), res, e.res);
        check($sformatf("latency%0d", sel), 128'(cyc), 128'(e.due));
        last_res[sel] = e.res;
      end
    end else begin
      if (qsize(sel) > 0) begin
        e = (sel == 0) ? q0[0] : q1[0];
        if (cyc >= e.due) begin
          checks++; failures++;
          $display("FAIL missing_valid%0d actual=0 required=1", sel);
          if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
      check($sformatf("hold%0d", sel), res, last_res[sel]);
    end
    exp_rdy = 1'b1;
    if (qsize(sel) > 0) begin
      e = (sel == 0) ? q0[0] : q1[0];
      if (e.acc <= cyc && cyc < e.due) exp_rdy = 1'b0;
    end
    check($sformatf("ready%0d", sel), 128'(rdy), 128'(exp_rdy));
  endtask

  always @(negedge clk) if (rst_n === 1'b1) mon(0, rv0, res0, rdy0);
  always @(negedge clk) if (rst_n === 1'b1) mon(1, rv1, res1, rdy1);

  // Drives start at a negedge; acceptance is the following rising edge.
  task automatic go(input int sel, input logic [127:0] b, input logic [255:0] k,
                    input bit use_kat, input logic [127:0] kat);
    exp_t e;
    int nk = (sel == 0) ? 4 : 8;
    e.res = use_kat ? kat : aes_ref(b, k, nk);
    e.acc = cyc + 1;
    e.due = cyc + 1 + nk + 6;
    if (sel == 0) begin
      start0 = 1'b1; blk0 = b; key0 = k[255:128]; q0.push_back(e);
    end else begin
      start1 = 1'b1; blk1 = b; key1 = k; q1.push_back(e);
    end
  endtask

  task automatic issue(input int sel, input logic [127:0] b, input logic [255:0] k,
                       input bit use_kat, input logic [127:0] kat);
    @(negedge clk);
    go(sel, b, k, use_kat, kat);
    @(negedge clk);
    if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    for (int i = 0; i < 40 && qsize(sel) > 0; i++) @(negedge clk);
    if (qsize(sel) > 0) begin
      checks++; failures++;
      $display("FAIL timeout%0d actual=%0d required=0", sel, qsize(sel));
      if (sel == 0) q0.delete(); else q1.delete();
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    blk0 = '0; blk1 = '0; key0 = '0; key1 = '0;
    last_res[0] = '0; last_res[1] = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_ready0", 128'(rdy0), 128'(1));
    check("rst_valid0", 128'(rv0), 128'(0));
    check("rst_result0", res0, 128'h0);
    check("rst_ready1", 128'(rdy1), 128'(1));
    check("rst_result1", res1, 128'h0);
    #2 rst_n = 1'b1;

    issue(0, 128'h3243f6a8885a308d313198a2e0370734,
          {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b1,
          128'h3925841d02dc09fbdc118597196a0b32);
    wait_done(0);
    issue(0, 128'h00112233445566778899aabbccddeeff,
          {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b1,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_done(0);
    issue(1, 128'h00112233445566778899aabbccddeeff,
          256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
          128'h8ea2b7ca516745bfeafc49904b496089);
    wait_done(1);

    for (int n = 0; n < 10; n++) begin
      int sel = (n < 6) ? 0 : 1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(sel, rnd128(), {rnd128(), rnd128()}, 1'b0, '0);
      wait_done(sel);
    end

    // Inputs and start churn while busy; only the original vector may complete.
    for (int sel = 0; sel < 2; sel++) begin
      @(negedge clk);
      go(sel, rnd128(), {rnd128(), rnd128()}, 1'b0, '0);
      for (int j = 0; j < ((sel == 0) ? 10 : 14); j++) begin
        @(negedge clk);
        if (sel == 0) begin
          start0 = 1'($urandom); blk0 = rnd128(); key0 = rnd128();
        end else begin
          start1 = 1'($urandom); blk1 = rnd128(); key1 = {rnd128(), rnd128()};
        end
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      wait_done(sel);
    end

    // Start held high across two vectors: second accepted the edge after result_valid.
    @(negedge clk);
    go(0, rnd128(), {rnd128(), 128'h0}, 1'b0, '0);
    @(negedge clk);
    begin
      exp_t e;
      logic [127:0] b2, k2;
      b2 = rnd128(); k2 = rnd128();
      blk0 = b2; key0 = k2;
      e.res = aes_ref(b2, {k2, 128'h0}, 4);
      e.acc = cyc + 11;
      e.due = cyc + 21;
      q0.push_back(e);
    end
    repeat (11) @(negedge clk);
    start0 = 1'b0;
    wait_done(0);

    // Reset at round 5 abandons the operation.
    issue(0, rnd128(), {rnd128(), 128'h0}, 1'b0, '0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    last_res[0] = '0; last_res[1] = '0;
    #1;
    check("midrst_ready0", 128'(rdy0), 128'(1));
    check("midrst_result0", res0, 128'h0);
    check("midrst_valid0", 128'(rv0), 128'(0));
    check("midrst_result1", res1, 128'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(0, rnd128(), {rnd128(), 128'h0}, 1'b0, '0);
    wait_done(0);
    issue(1, rnd128(), {rnd128(), rnd128()}, 1'b0, '0);
    wait_done(1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
